// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioning bank.
// Channel indices match the board's switch wiring.
package btn_pkg;

    localparam int BTN_DEBOUNCE_10MS = 500000;
    localparam int BTN_REPEAT_500MS  = 25000000;
    localparam int BTN_REPEAT_100MS  = 5000000;

    localparam int BTN_PADDLE_L  = 0;
    localparam int BTN_PADDLE_R  = 1;
    localparam int BTN_CAM_START = 2;
    localparam int BTN_AUX       = 3;

    // Counter width able to hold (largest cycle constant - 1); never below 1 bit.
    function automatic int btn_cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, edge strobes.
// With BTN_DEBOUNCE_AUTOREPEAT_EN the counter doubles as the auto-repeat timer.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = BTN_REPEAT_500MS,
    parameter int REPEAT_PERIOD   = BTN_REPEAT_100MS
) (
    input  logic clock,
    input  logic reset,
    input  logic i_noisy,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_press
);

    localparam int CNT_W = btn_cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_cur;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // r_busy marks that r_cnt holds a debounce count rather than a repeat count,
    // so a release always starts qualifying from zero.
    logic r_busy;
    logic r_phase;
    assign w_cnt_cur = r_busy ? r_cnt : '0;
`else
    assign w_cnt_cur = r_cnt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
`endif
        end else begin
            r_s1    <= i_noisy;
            r_s2    <= r_s1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= 1'b0;
            if (r_s2 != r_clean) begin
                if (w_cnt_cur == DB_LAST) begin
                    r_clean <= r_s2;
                    r_cnt   <= '0;
                    r_rise  <= r_s2;
                    r_fall  <= ~r_s2;
                    r_press <= r_s2;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    r_busy  <= 1'b0;
                    r_phase <= 1'b0;
`endif
                end else begin
                    r_cnt <= w_cnt_cur + 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    r_busy <= 1'b1;
`endif
                end
            end else begin
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                r_busy <= 1'b0;
                if (r_clean && !r_busy) begin
                    // First wait is the repeat delay, later waits the repeat period.
                    if (r_cnt == (r_phase ? PERIOD_LAST : DELAY_LAST)) begin
                        r_cnt   <= '0;
                        r_phase <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
`else
                r_cnt <= '0;
`endif
            end
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_press = r_press;

endmodule

// File: rtl/button_debounce_bank.sv
// Multi-channel push-button conditioner; optional auto-repeat enabled by
// defining BTN_DEBOUNCE_AUTOREPEAT_EN. This level only slices buses.
module button_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = BTN_REPEAT_500MS,
    parameter int REPEAT_PERIOD   = BTN_REPEAT_100MS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] noisy,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] press
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_ch (
                .clock   (clock),
                .reset   (reset),
                .i_noisy (noisy[gi]),
                .o_clean (clean[gi]),
                .o_rise  (rise[gi]),
                .o_fall  (fall[gi]),
                .o_press (press[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with a 4-cycle window; auto-repeat
// expectations follow BTN_DEBOUNCE_AUTOREPEAT_EN.
module tb_button_debounce_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] noisy;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] press;

    int tests = 0;
    int fails = 0;

    button_debounce_bank #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock (clk),
        .reset (reset),
        .noisy (noisy),
        .clean (clean),
        .rise  (rise),
        .fall  (fall),
        .press (press)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic       sticky;
        logic [7:0] bounce;
        logic       exp_p;

        reset = 1'b1;
        noisy = 4'b0000;
        tick(2);
        chk("reset_clean", 32'(clean), 32'h0);
        chk("reset_strobes", 32'({rise, fall, press}), 32'h0);
        reset = 1'b0;
        tick(2);

        // Clean press on channel 0: rise at edge 5 after first sampling edge.
        noisy = 4'b0001;
        tick(5);
        chk("press_pre_clean", 32'(clean), 32'h0);
        chk("press_pre_rise", 32'(rise), 32'h0);
        tick(1);
        chk("press_clean", 32'(clean), 32'h1);
        chk("press_rise", 32'(rise), 32'h1);
        chk("press_press", 32'(press), 32'h1);
        chk("press_fall", 32'(fall), 32'h0);
        tick(1);
        chk("press_rise_1cyc", 32'(rise), 32'h0);
        chk("press_clean_hold", 32'(clean), 32'h1);

        // Bounce on channel 1: never long enough to qualify.
        bounce = 8'b0111_0111;
        sticky = 1'b0;
        for (int i = 0; i < 8; i++) begin
            noisy[1] = bounce[i];
            tick(1);
            sticky = sticky | clean[1] | rise[1] | press[1];
        end
        noisy[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            sticky = sticky | clean[1] | rise[1] | press[1];
        end
        chk("bounce_no_output", 32'(sticky), 32'h0);
        chk("bounce_cnt_zero", 32'(dut.g_ch[1].u_ch.r_cnt), 32'h0);

        // Release channel 0.
        noisy[0] = 1'b0;
        tick(5);
        chk("rel_pre_fall", 32'(fall), 32'h0);
        chk("rel_pre_clean", 32'(clean), 32'h1);
        tick(1);
        chk("rel_fall", 32'(fall), 32'h1);
        chk("rel_rise", 32'(rise), 32'h0);
        chk("rel_clean", 32'(clean), 32'h0);
        tick(1);
        chk("rel_fall_1cyc", 32'(fall), 32'h0);

        // Hold channel 2: rise at T, repeats at T+10, T+13, T+16 when enabled.
        noisy[2] = 1'b1;
        tick(6);
        chk("rep_rise", 32'(rise), 32'h4);
        chk("rep_press_T", 32'(press), 32'h4);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            exp_p = (k == 10) || (k == 13) || (k == 16);
`else
            exp_p = 1'b0;
`endif
            chk($sformatf("rep_press_T+%0d", k), 32'(press[2]), 32'(exp_p));
        end
        noisy[2] = 1'b0;
        for (int k = 17; k <= 24; k++) begin
            tick(1);
            chk($sformatf("rel2_press_T+%0d", k), 32'(press[2]), 32'h0);
            chk($sformatf("rel2_fall_T+%0d", k), 32'(fall[2]), 32'(k == 22));
        end
        chk("rel2_clean", 32'(clean), 32'h0);

        // Reset mid-count on channel 3.
        noisy[3] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rst_mid_outputs", 32'({clean, rise, fall, press}), 32'h0);
        chk("rst_mid_cnt", 32'(dut.g_ch[3].u_ch.r_cnt), 32'h0);
        reset = 1'b0;
        tick(5);
        chk("rst_requal_pre", 32'(rise), 32'h0);
        tick(1);
        chk("rst_requal_rise", 32'(rise), 32'h8);
        chk("rst_requal_clean", 32'(clean), 32'h8);

        // All channels together.
        noisy = 4'b0000;
        tick(8);
        chk("all_idle", 32'(clean), 32'h0);
        noisy = 4'b1111;
        tick(5);
        chk("all_pre_rise", 32'(rise), 32'h0);
        tick(1);
        chk("all_rise", 32'(rise), 32'hF);
        chk("all_press", 32'(press), 32'hF);
        chk("all_clean", 32'(clean), 32'hF);
        tick(1);
        chk("all_rise_1cyc", 32'(rise), 32'h0);
        chk("all_no_fall", 32'(fall), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
